// File: rtl/fsm_mon_pkg.sv
// rtl/fsm_mon_pkg.sv - shared types and constants for the state-decode pulse monitor
package fsm_mon_pkg;

  // Monitor FSM: IDLE (disabled), ARM (waiting for first edge), MEAS (timing intervals)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } mon_state_e;

  // Default record layout; the top rebuilds the same layout at its own CNT_W
  localparam int REC_CNT_W = 8;

  typedef struct packed {
    logic [REC_CNT_W-1:0] interval;
    logic                 err;
  } mon_rec_t;

  localparam logic [15:0] PCNT_MAX = 16'hFFFF;

endpackage

// File: rtl/fsm_mon_fifo.sv
// rtl/fsm_mon_fifo.sv - small synchronous record FIFO with registered push
module fsm_mon_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  // Head is forced to zero when empty so stale storage never reaches the outputs
  assign rdata   = empty ? '0 : mem[rptr];

  // Storage write; contents need no reset since reads are masked by empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (arst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/fsm_pulse_monitor.sv
// rtl/fsm_pulse_monitor.sv - interval, lock and overflow monitor for the controller state-decode pulse
module fsm_pulse_monitor
  import fsm_mon_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 4,
  parameter int TOL        = 0,
  parameter int DEPTH      = 4,
  parameter int LOCK_N     = 3
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  input  logic             pulse_in,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_interval,
  output logic             rec_err,
  output logic [15:0]      pulse_count,
  output logic             synced,
  output logic             overflow
);

  typedef struct packed {
    logic [CNT_W-1:0] interval;
    logic             err;
  } rec_t;

  localparam int LOCK_W = $clog2(LOCK_N + 1);
  localparam logic [LOCK_W-1:0]   LOCK_MAX    = LOCK_W'(LOCK_N);
  localparam logic [CNT_W-1:0]    TIMEOUT_CNT = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic signed [CNT_W:0] EXP_S     = (CNT_W+1)'(EXP_PERIOD);
  localparam logic signed [CNT_W:0] TOL_S     = (CNT_W+1)'(TOL);

  mon_state_e        state;
  mon_state_e        state_nxt;
  logic              pulse_d;
  logic              pulse_edge;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              rec_push;
  rec_t              rec_d;
  rec_t              rec_q;
  logic [LOCK_W-1:0] lock_cnt;
  logic [LOCK_W-1:0] lock_nxt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              rec_pop;

  // Out-of-tolerance test on a signed difference one bit wider than the interval
  function automatic logic interval_err(input logic [CNT_W-1:0] iv);
    logic signed [CNT_W:0] diff;
    diff = $signed({1'b0, iv}) - EXP_S;
    if (diff < 0) diff = -diff;
    return diff > TOL_S;
  endfunction

  assign pulse_edge   = pulse_in & ~pulse_d;
  assign cnt_inc      = cnt + 1'b1;
  assign rec_valid    = ~fifo_empty;
  assign rec_pop      = rec_valid & rec_ready;
  assign rec_interval = rec_q.interval;
  assign rec_err      = rec_q.err;

  // Next state, interval counter and record generation; disable wins over everything
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rec_push  = 1'b0;
    rec_d     = '0;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ARM;
          cnt_nxt   = '0;
        end
        ARM: begin
          if (pulse_edge) state_nxt = MEAS;
          cnt_nxt = '0;
        end
        MEAS: begin
          if (pulse_edge) begin
            rec_push       = 1'b1;
            rec_d.interval = cnt_inc;
            rec_d.err      = interval_err(cnt_inc);
            cnt_nxt        = '0;
          end else if (cnt == TIMEOUT_CNT) begin
            rec_push       = 1'b1;
            rec_d.interval = '1;
            rec_d.err      = 1'b1;
            state_nxt      = ARM;
            cnt_nxt        = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Lock counter: good records climb to LOCK_N, a bad record or disable drops to zero
  always_comb begin
    lock_nxt = lock_cnt;
    if (!en) begin
      lock_nxt = '0;
    end else if (rec_push) begin
      if (rec_d.err)                lock_nxt = '0;
      else if (lock_cnt != LOCK_MAX) lock_nxt = lock_cnt + 1'b1;
    end
  end

  // State, edge history, counters and sticky flags
  always_ff @(posedge clk) begin
    if (arst) begin
      state       <= IDLE;
      pulse_d     <= 1'b0;
      cnt         <= '0;
      lock_cnt    <= '0;
      synced      <= 1'b0;
      pulse_count <= '0;
      overflow    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pulse_d  <= pulse_in;
      cnt      <= cnt_nxt;
      lock_cnt <= lock_nxt;
      synced   <= (lock_nxt == LOCK_MAX);
      if (en && pulse_edge && pulse_count != PCNT_MAX) pulse_count <= pulse_count + 1'b1;
      if (rec_push && fifo_full && !rec_pop) overflow <= 1'b1;
    end
  end

  fsm_mon_fifo #(
    .DEPTH (DEPTH),
    .W     (CNT_W + 1)
  ) u_fifo (
    .clk   (clk),
    .arst  (arst),
    .push  (rec_push),
    .wdata (rec_d),
    .pop   (rec_pop),
    .rdata (rec_q),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: doc/fsm_pulse_monitor.md
Name: fsm_pulse_monitor

Overview:
Downstream consumer of the single-bit state-decode output of the 3-bit CPL_FF-based controller FSM; that output is high while the FSM sits in state 3'b001.
- Measures the cycle interval between successive rising edges of that decode.
- Checks each interval against an expected period and buffers interval records in a small FIFO behind a valid/ready interface.
- Maintains a saturating edge count, a "synced" lock indicator and a sticky overflow flag for the checker/testbench layer.

Parameters:
CNT_W, 8, width of the interval counter and of rec_interval
EXP_PERIOD, 4, expected edge-to-edge interval in cycles
TOL, 0, allowed absolute deviation from EXP_PERIOD in cycles
DEPTH, 4, record FIFO depth (power of two, >= 2)
LOCK_N, 3, consecutive in-tolerance intervals required to assert synced

Ports:
clk  input  1  single clock; all state updates on the rising edge
arst  input  1  synchronous active-high reset
en  input  1  monitor enable
pulse_in  input  1  FSM state-decode output (high while cs == 3'b001)
rec_valid  output  1  FIFO head holds a record
rec_ready  input  1  consumer accepts the head record this cycle
rec_interval  output  CNT_W  interval of the head record in cycles
rec_err  output  1  head record is out of tolerance or a timeout
pulse_count  output  16  rising edges seen while en, saturating at 16'hFFFF
synced  output  1  lock indicator
overflow  output  1  sticky: a record was dropped because the FIFO was full

Behaviour:
- Reset: arst is sampled on the clk edge only (synchronous, active-high). When asserted it forces:
  - state = IDLE, pulse_d = 0, interval counter = 0, FIFO empty;
  - rec_valid = 0, rec_interval = 0, rec_err = 0;
  - pulse_count = 0, synced = 0, overflow = 0, lock counter = 0.
- Reset has priority over every other event. Reset mid-measurement discards all in-flight and buffered data.
- Edge detect: edge = pulse_in & ~pulse_d. pulse_d registers pulse_in every cycle, regardless of en. Because pulse_d resets to 0, pulse_in high on the first cycle after reset counts as an edge.
- State machine:
  - IDLE: counter held at 0. If en = 1, go to ARM.
  - ARM: waits for the first edge. On edge, go to MEAS with the counter set to 0. No record is produced for the first edge.
  - MEAS: the counter increments every cycle.
    - On edge: produce a record with interval = counter + 1 (edges at cycles t1 and t2 give t2 - t1). Counter returns to 0; stay in MEAS.
    - Timeout: if the counter reaches 2^CNT_W - 2 with no edge, produce a record with interval = all-ones and err = 1, then go to ARM.
  - From any state, en = 0 goes to IDLE on the next edge and clears the counter and the lock counter. FIFO contents, pulse_count and overflow are retained.
- Record err = (|interval - EXP_PERIOD| > TOL), computed in CNT_W+1-bit signed arithmetic. A timeout record always has err = 1.
- FIFO:
  - Record push is registered: a record produced in cycle t is visible at the head (rec_valid = 1) in cycle t+1 at the earliest. There is no combinational bypass.
  - Pop occurs when rec_valid & rec_ready.
  - Push while full is accepted only if a pop happens in the same cycle. Otherwise the record is dropped and overflow sets and stays set until arst.
  - Simultaneous push and pop on an empty FIFO cannot happen, since rec_valid is 0 when empty.
  - rec_interval and rec_err are held stable while rec_valid = 1 and rec_ready = 0.
- pulse_count increments on every edge while en = 1, including the first edge, and saturates at 16'hFFFF.
- synced:
  - The lock counter increments on each err = 0 record and saturates at LOCK_N.
  - synced = (lock counter == LOCK_N), registered: it asserts the cycle after the LOCK_N-th good record is produced.
  - Any err = 1 record or en = 0 clears the lock counter and synced on the next edge.

Decomposition:
- Shared package fsm_mon_pkg holds:
  - the state enum (IDLE, ARM, MEAS);
  - a record struct {interval[CNT_W-1:0], err};
  - the constant PCNT_MAX = 16'hFFFF.
- One sub-module: fsm_mon_fifo, a parameterised synchronous FIFO (DEPTH, payload width) with push/pop/full/empty. The top holds the edge detect, FSM, counters and lock logic.

Test Plan:
- Periodic pulse, period 4 (default params), en = 1, 5 edges, rec_ready = 1 -> 4 records, each with interval = 4 and err = 0; synced rises the cycle after the 3rd record is produced; pulse_count = 5.
- Pulse period 6 with EXP_PERIOD = 4, TOL = 1 -> every record has interval = 6 and err = 1; synced stays 0.
- rec_ready = 0, period 4, 6 edges (DEPTH = 4) -> 5 records produced; first 4 buffered; overflow = 1 on the 5th; draining yields exactly 4 records with interval = 4.
- One edge, then pulse_in held low for 260 cycles (CNT_W = 8) -> one timeout record with interval = 8'hFF, err = 1; state returns to ARM; the next two edges 4 cycles apart give interval = 4.
- arst asserted for 1 cycle mid-MEAS with 2 buffered records -> the next cycle shows rec_valid = 0, pulse_count = 0, overflow = 0, synced = 0; pulse_in high on the first post-reset cycle with en = 1 counts as an edge (pulse_count = 1).
- en dropped for 10 cycles during periodic pulses -> no records are produced and pulse_count does not advance while en = 0; after en returns, the first edge only re-arms, and records resume from the second edge.
